// File: rtl/data_memory_responder_pkg.sv
// Shared constants for the data-memory responder: boolean levels, access sizes,
// responder state encodings and a lane write-enable helper.
package data_memory_responder_pkg;

  localparam logic TRUE     = 1'b1;
  localparam logic FALSE    = 1'b0;

  localparam logic MEM_WORD = 1'b0;
  localparam logic MEM_BYTE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_READ_WAIT = 2'd1,
    ST_READ_DATA = 2'd2,
    ST_WRITE     = 2'd3
  } resp_state_t;

  // Byte-lane write enables for a store of the given size at the given lane.
  function automatic logic [3:0] lane_we(input logic size, input logic [1:0] lane);
    if (size == MEM_WORD) return 4'b1111;
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/data_memory_array.sv
// 2**ADDR_WIDTH x 32-bit storage with per-lane synchronous write enables and a
// combinational read port sharing the same word address.
module data_memory_array
  import data_memory_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic [3:0]            byte_we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [31:0] mem [DEPTH];

  // NOTE: the storage array has no reset; clearing it would force a flop-based
  // implementation instead of RAM, and software never relies on its contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (byte_we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory slave on the MEMORY_STAGE bus: one load or store at a time, with
// programmable load/store latency, error detection and a tri-state read driver.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int ADDR_WIDTH    = 10,
  parameter int READ_LATENCY  = 1,
  parameter int WRITE_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_in_req_valid_l,
  input  logic        mem_in_memory_we2_l,
  input  logic        mem_in_size_l,
  input  logic [31:0] mem_in_memory_address_l,
  inout  wire  [31:0] mem_io_memory_data_l,
  output logic        mem_out_ready_l,
  output logic        mem_out_rdata_valid_l,
  output logic        mem_out_error_l
);

  localparam int CNT_MAX = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  resp_state_t            state;
  logic [CNT_W-1:0]       cnt;
  logic [31:0]            rdata_q;
  logic                   load_err_q;

  logic                   accept;
  logic [ADDR_WIDTH-1:0]  word_idx;
  logic [1:0]             lane;
  logic                   out_of_range;
  logic                   misaligned;
  logic                   access_err;
  logic [3:0]             byte_we;
  logic [31:0]            wdata;
  logic [31:0]            rd_word;
  logic [7:0]             lane_byte;
  logic [31:0]            load_data;

  assign accept       = mem_in_req_valid_l && mem_out_ready_l && !reset;
  assign word_idx     = mem_in_memory_address_l[ADDR_WIDTH+1:2];
  assign lane         = mem_in_memory_address_l[1:0];
  assign out_of_range = |mem_in_memory_address_l[31:ADDR_WIDTH+2];
  assign misaligned   = (mem_in_size_l == MEM_WORD) && (lane != 2'd0);
  assign access_err   = out_of_range || misaligned;

  // Stores commit at the end of the accept cycle, straight from the shared bus.
  assign byte_we   = (accept && mem_in_memory_we2_l && !access_err)
                     ? lane_we(mem_in_size_l, lane) : 4'b0000;
  assign wdata     = (mem_in_size_l == MEM_WORD) ? mem_io_memory_data_l
                                                 : {4{mem_io_memory_data_l[7:0]}};

  assign lane_byte = 8'(rd_word >> {lane, 3'b000});
  assign load_data = access_err                 ? 32'h0 :
                     (mem_in_size_l == MEM_BYTE) ? {24'h0, lane_byte} : rd_word;

  data_memory_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk     (clk),
    .byte_we (byte_we),
    .addr    (word_idx),
    .wdata   (wdata),
    .rdata   (rd_word)
  );

  // NOTE: every register here is assigned with <= so all state updates
  // together from values sampled at the same clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= ST_IDLE;
      cnt                   <= '0;
      rdata_q               <= 32'h0;
      load_err_q            <= FALSE;
      mem_out_ready_l       <= TRUE;
      mem_out_rdata_valid_l <= FALSE;
      mem_out_error_l       <= FALSE;
    end else begin
      mem_out_error_l <= FALSE;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            mem_out_ready_l <= FALSE;
            if (mem_in_memory_we2_l) begin
              state           <= ST_WRITE;
              cnt             <= CNT_W'(WRITE_LATENCY - 1);
              mem_out_error_l <= access_err;
            end else begin
              // Read data is captured now; no store can slip in before it is returned.
              rdata_q    <= load_data;
              load_err_q <= access_err;
              cnt        <= CNT_W'(READ_LATENCY - 1);
              if (READ_LATENCY == 1) begin
                state                 <= ST_READ_DATA;
                mem_out_rdata_valid_l <= TRUE;
                mem_out_error_l       <= access_err;
              end else begin
                state <= ST_READ_WAIT;
              end
            end
          end
        end
        ST_READ_WAIT: begin
          // rdata_valid is registered, so the data cycle is entered as the
          // count runs out; it then lands exactly READ_LATENCY cycles after accept.
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state                 <= ST_READ_DATA;
            mem_out_rdata_valid_l <= TRUE;
            mem_out_error_l       <= load_err_q;
          end
        end
        ST_READ_DATA: begin
          state                 <= ST_IDLE;
          mem_out_rdata_valid_l <= FALSE;
          mem_out_ready_l       <= TRUE;
        end
        ST_WRITE: begin
          if (cnt == '0) begin
            state           <= ST_IDLE;
            mem_out_ready_l <= TRUE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem_io_memory_data_l = mem_out_rdata_valid_l ? rdata_q : 'z;

endmodule
